// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding imem fetch and 2-entry instruction buffer.
// Define IFETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        misalign_err
);
`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, READY, WAIT, DROP, HALT} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_drop_addr;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_misalign;
    logic        w_mis, w_mis_next, w_push, w_pop, w_pending, w_tail;
    logic [31:0] w_target;
    assign w_mis = TRAP && (redirect_addr[1:0] != 2'b00);
    assign w_target = TRAP ? redirect_addr : {redirect_addr[31:2], 2'b00};
    assign w_mis_next = redirect ? w_mis : r_misalign;
    assign imem_req = (r_state == READY && r_count != 2'd2) || r_state == WAIT || r_state == DROP;
    // DROP keeps presenting the abandoned address while pc already holds the new target
    assign imem_addr = r_state == DROP ? r_drop_addr : r_pc;
    assign w_pending = imem_req && !imem_ack;
    assign w_push = imem_req && imem_ack && !redirect && (r_state == READY || r_state == WAIT);
    assign w_pop = instr_valid && decode_ready && !redirect;
    assign w_tail = r_head ^ r_count[0];
    assign instr_valid = r_count != 2'd0;
    assign instr = r_q_instr[r_head];
    assign instr_pc = r_q_pc[r_head];
    assign misalign_err = r_misalign;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        w_next = w_mis_next ? HALT : READY;
            READY, WAIT: w_next = redirect ? (w_pending ? DROP : (w_mis ? HALT : READY))
                                           : (w_pending ? WAIT : READY);
            DROP:        w_next = imem_ack ? (w_mis_next ? HALT : READY) : DROP;
            HALT:        w_next = (redirect && !w_mis) ? READY : HALT;
            default:     w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_head      <= 1'b0;
            r_count     <= 2'd0;
            r_misalign  <= 1'b0;
            r_q_instr   <= '{default: '0};
            r_q_pc      <= '{default: '0};
        end else begin
            r_state    <= w_next;
            r_misalign <= w_mis_next;
            if (redirect)
                r_pc <= w_target;
            else if (w_push)
                r_pc <= r_pc + 32'd4;
            if (r_state != DROP)
                r_drop_addr <= r_pc;
            if (w_push) begin
                r_q_instr[w_tail] <= imem_rdata;
                r_q_pc[w_tail]    <= r_pc;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= redirect ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
